pe_multi_filter_mac: RTL



---
 rtl/pe_multi_filter_mac.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pe_multi_filter_mac.sv
// pe_multi_filter_mac: buffers one IF window and runs up to NUM_FILT stored filters over it,
// streaming one (optionally psum-augmented) result per filter.
module pe_multi_filter_mac #(
    parameter int IF_WIDTH   = 8,
    parameter int FILT_WIDTH = 8,
    parameter int FILT_DEPTH = 16,
    parameter int NUM_FILT   = 4,
    parameter int ACC_WIDTH  = IF_WIDTH + FILT_WIDTH + $clog2(FILT_DEPTH)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     filt_wen,
    input  logic [$clog2(NUM_FILT*FILT_DEPTH)-1:0]   filt_waddr,
    input  logic [FILT_WIDTH-1:0]                    filt_wdata,
    input  logic                                     start,
    input  logic [$clog2(FILT_DEPTH+1)-1:0]          filt_len,
    input  logic [$clog2(NUM_FILT+1)-1:0]            num_filt,
    input  logic                                     if_shift,
    input  logic [$clog2(FILT_DEPTH+1)-1:0]          stride,
    input  logic                                     psum_en,
    input  logic                                     if_valid,
    output logic                                     if_ready,
    input  logic [IF_WIDTH-1:0]                      if_data,
    input  logic                                     psum_valid,
    output logic                                     psum_ready,
    input  logic [ACC_WIDTH-1:0]                     psum_in,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [ACC_WIDTH:0]                       out_data,
    output logic                                     out_last,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     cmd_err
);
    localparam int AW = $clog2(NUM_FILT * FILT_DEPTH);
    localparam int LW = $clog2(FILT_DEPTH + 1);
    localparam int NW = $clog2(NUM_FILT + 1);
    localparam int KW = $clog2(FILT_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, OUT} state_t;
    state_t state, nxt;

    logic [LW-1:0] len_r, stride_r, ld_cnt, k, ld_n;
    logic [NW-1:0] nf_r, f;
    logic shift_r, pen_r, first_ld, dr, v1, v2;
    logic cmd_ok, accept, xfer, last_f;
    logic [IF_WIDTH-1:0] win [FILT_DEPTH];
    logic [FILT_WIDTH-1:0] wgt [NUM_FILT*FILT_DEPTH];
    logic [IF_WIDTH-1:0] s1_x;
    logic [FILT_WIDTH-1:0] s1_w;
    logic [IF_WIDTH+FILT_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] acc;
    logic [AW-1:0] raddr;

    assign cmd_ok = filt_len != '0 && filt_len <= LW'(FILT_DEPTH) && num_filt != '0 &&
                    num_filt <= NW'(NUM_FILT) && !(if_shift && (stride == '0 || stride > filt_len));
    assign ld_n       = shift_r ? stride_r : len_r;
    assign if_ready   = state == LOAD && ld_cnt < ld_n;
    assign accept     = if_valid && if_ready;
    assign last_f     = f == nf_r - NW'(1);
    assign out_valid  = state == OUT && (pen_r ? psum_valid : 1'b1);
    assign psum_ready = state == OUT && pen_r && out_ready;
    assign xfer       = out_valid && out_ready;
    assign out_last   = state == OUT && last_f;
    assign out_data   = state == OUT ? {1'b0, acc} + (pen_r ? {1'b0, psum_in} : '0) : '0;
    assign busy       = state != IDLE;
    assign raddr      = AW'(f) * AW'(FILT_DEPTH) + AW'(k);

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = start && cmd_ok ? LOAD : IDLE;
            LOAD:    nxt = accept && ld_cnt == ld_n - LW'(1) ? MAC : LOAD;
            MAC:     nxt = k == len_r - LW'(1) ? DRAIN : MAC;
            DRAIN:   nxt = dr ? OUT : DRAIN;
            OUT:     nxt = xfer ? (last_f ? IDLE : MAC) : OUT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!rst) state <= IDLE;
        else state <= nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            {len_r, stride_r, ld_cnt, k, nf_r, f} <= '0;
            {shift_r, pen_r, first_ld, dr, v1, v2, done, cmd_err} <= '0;
            {s1_x, s1_w, prod, acc} <= '0;
        end else begin
            done    <= state == OUT && nxt == IDLE;
            cmd_err <= state == IDLE && start && !cmd_ok;
            v1      <= state == MAC;
            v2      <= v1;
            dr      <= state == DRAIN ? ~dr : 1'b0;
            s1_x    <= win[KW'(k)];
            s1_w    <= wgt[raddr];
            prod    <= {{FILT_WIDTH{1'b0}}, s1_x} * {{IF_WIDTH{1'b0}}, s1_w};
            if (state == IDLE && start && cmd_ok) begin
                len_r    <= filt_len;
                nf_r     <= num_filt;
                shift_r  <= if_shift;
                stride_r <= stride;
                pen_r    <= psum_en;
                ld_cnt   <= '0;
                f        <= '0;
                first_ld <= 1'b1;
            end
            if (state == LOAD) first_ld <= 1'b0;
            if (accept) ld_cnt <= ld_cnt + LW'(1);
            if (state == MAC) k <= k + LW'(1);
            // every filter starts from a clean accumulator; the pipeline is empty on entry
            if (nxt == MAC && state != MAC) begin
                k   <= '0;
                acc <= '0;
            end else if (v2) begin
                acc <= acc + ACC_WIDTH'(prod);
            end
            if (xfer && !last_f) f <= f + NW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && filt_wen) wgt[filt_waddr] <= filt_wdata;
        if (state == LOAD && first_ld && shift_r)
            for (int i = 0; i < FILT_DEPTH; i++)
                if (i + int'(stride_r) < int'(len_r)) win[KW'(i)] <= win[KW'(i + int'(stride_r))];
        if (accept) win[KW'(len_r - ld_n + ld_cnt)] <= if_data;
    end
endmodule
